// File: rtl/tiger_hazard_pkg.sv
// Shared defaults, pipeline stage indices and latency type for the hazard scoreboard.
package tiger_hazard_pkg;
    localparam int NUM_STAGES_DEF = 5;
    localparam int NUM_REGS_DEF   = 32;
    localparam int LAT_W_DEF      = 3;
    localparam int CNT_W_DEF      = 16;

    localparam int STG_DE = 0;
    localparam int STG_EX = 1;
    localparam int STG_MA = 2;
    localparam int STG_WB = NUM_STAGES_DEF - 1;

    typedef logic [LAT_W_DEF-1:0] latT;
endpackage

// File: rtl/tiger_sb_entry.sv
// One scoreboard pending counter: counts down while the pipe advances, reloads on issue.
module tiger_sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             advance,
    input  logic             load,
    input  logic [LAT_W-1:0] loadLat,
    output logic             pending
);
    logic [LAT_W-1:0] cntReg;
    logic [LAT_W-1:0] cntNext;
    logic [LAT_W-1:0] decVal;

    // Reload never shortens an in-flight write, so an older slow producer still interlocks.
    always_comb begin
        decVal  = (advance && (cntReg != '0)) ? cntReg - LAT_W'(1) : cntReg;
        cntNext = decVal;
        if (flush) begin
            cntNext = '0;
        end else if (load && (loadLat > decVal)) begin
            cntNext = loadLat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cntReg <= '0;
        end else begin
            cntReg <= cntNext;
        end
    end

    assign pending = (cntReg != '0) && !reset;
endmodule

// File: rtl/tiger_hazard_scoreboard.sv
// RAW interlock scoreboard with per-stage stall/bubble generation and a stall-cycle counter.
module tiger_hazard_scoreboard
    import tiger_hazard_pkg::*;
#(
    parameter int NUM_STAGES = NUM_STAGES_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int LAT_W      = LAT_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    localparam int REG_W     = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_W-1:0]      issue_rs,
    input  logic [REG_W-1:0]      issue_rt,
    input  logic                  issue_use_rs,
    input  logic                  issue_use_rt,
    input  logic                  issue_wr_en,
    input  logic [REG_W-1:0]      issue_wr_reg,
    input  logic [LAT_W-1:0]      issue_lat,
    input  logic [NUM_STAGES-1:0] stage_stall_rq,
    input  logic                  ext_stall,
    input  logic                  flush,
    input  logic                  perf_clr,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] clear,
    output logic                  hazard,
    output logic [CNT_W-1:0]      stall_cycles
);
    logic [NUM_REGS-1:0]   pendVec;
    logic [NUM_STAGES-1:0] needVec;
    logic                  issueFire;
    logic                  advance;
    logic                  rsHit;
    logic                  rtHit;
    logic [CNT_W-1:0]      stallCntReg;

    assign pendVec[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_entry
            tiger_sb_entry #(.LAT_W(LAT_W)) u_entry (
                .clk     (clk),
                .reset   (reset),
                .flush   (flush),
                .advance (advance),
                .load    (issueFire && (issue_wr_reg == REG_W'(gi))),
                .loadLat (issue_lat),
                .pending (pendVec[gi])
            );
        end
    endgenerate

    assign rsHit  = issue_use_rs && (issue_rs != '0) && pendVec[issue_rs];
    assign rtHit  = issue_use_rt && (issue_rt != '0) && pendVec[issue_rt];
    assign hazard = issue_valid && (rsHit || rtHit);

    always_comb begin
        needVec         = stage_stall_rq;
        needVec[STG_DE] = hazard || stage_stall_rq[STG_DE] || ext_stall;
    end

    // A stage holds if it or anything downstream of it needs to hold.
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stall
            assign stall[gi] = |needVec[NUM_STAGES-1:gi];
            if (gi == 0) begin : g_clr0
                assign clear[gi] = flush && !stall[gi];
            end else begin : g_clrn
                assign clear[gi] = needVec[gi-1] && !stall[gi];
            end
        end
    endgenerate

    assign issueFire = issue_valid && issue_wr_en && (issue_wr_reg != '0)
                       && !stall[STG_DE] && !flush;
    assign advance   = !stall[STG_EX];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCntReg <= '0;
        end else if (perf_clr) begin
            stallCntReg <= '0;
        end else if (stall[STG_DE] && (stallCntReg != '1)) begin
            stallCntReg <= stallCntReg + CNT_W'(1);
        end
    end

    assign stall_cycles = stallCntReg;
endmodule

// File: tb/tb_tiger_hazard_scoreboard.sv
// Directed scenarios plus randomized traffic checked against a per-register countdown model.
module tb_tiger_hazard_scoreboard;
    localparam int NS = 5;
    localparam int NR = 32;
    localparam int LW = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic [4:0]    issue_rs, issue_rt, issue_wr_reg;
    logic          issue_use_rs, issue_use_rt, issue_wr_en;
    logic [LW-1:0] issue_lat;
    logic [NS-1:0] stage_stall_rq;
    logic          ext_stall, flush, perf_clr;
    logic [NS-1:0] stall, clear;
    logic          hazard;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    int            mc[NR];
    int            mSc;
    logic          eHaz;
    logic [NS-1:0] eStall, eClear;

    tiger_hazard_scoreboard #(.NUM_STAGES(NS), .NUM_REGS(NR), .LAT_W(LW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
        .issue_wr_en(issue_wr_en), .issue_wr_reg(issue_wr_reg), .issue_lat(issue_lat),
        .stage_stall_rq(stage_stall_rq), .ext_stall(ext_stall), .flush(flush),
        .perf_clr(perf_clr), .stall(stall), .clear(clear), .hazard(hazard),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Expected combinational outputs from the model's remaining-latency table.
    function automatic void model_comb();
        logic [NS-1:0] need;
        logic pr, pt;
        pr = issue_use_rs && (issue_rs != 0) && (mc[issue_rs] > 0) && !reset;
        pt = issue_use_rt && (issue_rt != 0) && (mc[issue_rt] > 0) && !reset;
        eHaz = issue_valid && (pr || pt);
        need = stage_stall_rq;
        need[0] = eHaz || stage_stall_rq[0] || ext_stall;
        for (int i = 0; i < NS; i++) begin
            eStall[i] = 1'b0;
            for (int j = i; j < NS; j++) if (need[j]) eStall[i] = 1'b1;
        end
        eClear[0] = flush && !eStall[0];
        for (int i = 1; i < NS; i++) eClear[i] = need[i-1] && !eStall[i];
    endfunction

    task automatic tick();
        logic fire;
        int v;
        model_comb();
        if (reset) begin
            for (int r = 0; r < NR; r++) mc[r] = 0;
            mSc = 0;
        end else begin
            fire = issue_valid && issue_wr_en && (issue_wr_reg != 0) && !eStall[0] && !flush;
            for (int r = 1; r < NR; r++) begin
                v = mc[r];
                if (!eStall[1] && v > 0) v = v - 1;
                if (flush) v = 0;
                else if (fire && issue_wr_reg == 5'(r) && int'(issue_lat) > v) v = int'(issue_lat);
                mc[r] = v;
            end
            if (perf_clr) mSc = 0;
            else if (eStall[0] && mSc < 65535) mSc = mSc + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_use_rs = 0; issue_use_rt = 0;
        issue_wr_en = 0; issue_wr_reg = 0; issue_lat = 0; stage_stall_rq = 0;
        ext_stall = 0; flush = 0; perf_clr = 0;
    endtask

    task automatic issue_w(input logic [4:0] r, input logic [LW-1:0] lat);
        idle();
        issue_valid = 1; issue_wr_en = 1; issue_wr_reg = r; issue_lat = lat;
    endtask

    task automatic consume(input logic [4:0] r);
        idle();
        issue_valid = 1; issue_use_rs = 1; issue_rs = r;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        consume(5);
        #1;
        checks++; if (stall_cycles !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h want 0000", stall_cycles); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b want 0", hazard); end
        checks++; if (stall !== 5'b0) begin errors++; $display("FAIL reset_stall got %b want 00000", stall); end
        tick(); tick();
        reset = 0;
        idle();
        #1;
        $display("reset: stall=%b clear=%b cnt=%0d", stall, clear, stall_cycles);
    endtask

    task automatic test_raw();
        issue_w(5, 2); #1;
        checks++; if (stall !== 5'b0) begin errors++; $display("FAIL raw_issue_stall got %b want 00000", stall); end
        tick();
        consume(5);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL raw_hazard cyc%0d got %b want 1", k, hazard); end
            checks++; if (clear[1] !== 1'b1) begin errors++; $display("FAIL raw_clear1 cyc%0d got %b want 1", k, clear[1]); end
            checks++; if (stall !== 5'b00001) begin errors++; $display("FAIL raw_stall cyc%0d got %b want 00001", k, stall); end
            tick();
        end
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL raw_release got %b want 0", hazard); end
        $display("raw: r5 lat2 consumer released");
        tick();
    endtask

    task automatic test_r0();
        issue_w(0, 3); tick();
        consume(0); issue_use_rt = 1; issue_rt = 0; #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL r0_hazard got %b want 0", hazard); end
        $display("r0: hazard=%b", hazard);
        tick();
    endtask

    task automatic test_stage_stall();
        issue_w(7, 2); tick();
        consume(7); stage_stall_rq = 5'b01000;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (stall !== 5'b01111) begin errors++; $display("FAIL stg_stall cyc%0d got %b want 01111", k, stall); end
            checks++; if (clear[4] !== 1'b1) begin errors++; $display("FAIL stg_clear4 cyc%0d got %b want 1", k, clear[4]); end
            tick();
        end
        stage_stall_rq = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL stg_hold_hazard cyc%0d got %b want 1", k, hazard); end
            tick();
        end
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL stg_release got %b want 0", hazard); end
        $display("stage_stall: r7 held across 4 stalled cycles");
        tick();
    endtask

    task automatic test_waw();
        int n;
        issue_w(9, 1); tick();
        issue_w(9, 4); tick();
        consume(9);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (hazard === 1'b1) n++;
            tick();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL waw_stall_cycles got %0d want 4", n); end
        $display("waw: r9 consumer stalled %0d cycles", n);
    endtask

    task automatic test_flush();
        issue_w(3, 5); tick();
        issue_w(4, 6); tick();
        issue_w(6, 3); flush = 1; #1;
        checks++; if (clear[0] !== 1'b1) begin errors++; $display("FAIL flush_clear0 got %b want 1", clear[0]); end
        tick();
        consume(3); issue_use_rt = 1; issue_rt = 4; #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL flush_r3r4 got %b want 0", hazard); end
        tick();
        consume(6); #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL flush_issue_ignored got %b want 0", hazard); end
        $display("flush: r3/r4 cleared, r6 issue dropped");
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            idle();
            issue_valid    = ($urandom_range(0, 3) != 0);
            issue_rs       = 5'($urandom_range(0, 7));
            issue_rt       = 5'($urandom_range(0, 7));
            issue_use_rs   = 1'($urandom_range(0, 1));
            issue_use_rt   = 1'($urandom_range(0, 1));
            issue_wr_en    = 1'($urandom_range(0, 1));
            issue_wr_reg   = 5'($urandom_range(0, 7));
            issue_lat      = LW'($urandom_range(0, 7));
            for (int s = 0; s < NS; s++) stage_stall_rq[s] = ($urandom_range(0, 9) == 0);
            ext_stall      = ($urandom_range(0, 7) == 0);
            flush          = ($urandom_range(0, 31) == 0);
            perf_clr       = ($urandom_range(0, 31) == 0);
            #1;
            model_comb();
            checks++;
            if (hazard !== eHaz || stall !== eStall || clear !== eClear || stall_cycles !== CW'(mSc)) begin
                errors++;
                $display("FAIL rand%0d got h=%b s=%b c=%b n=%0d want h=%b s=%b c=%b n=%0d",
                         k, hazard, stall, clear, stall_cycles, eHaz, eStall, eClear, mSc);
            end else begin
                $display("rand%0d h=%b s=%b c=%b n=%0d", k, hazard, stall, clear, stall_cycles);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        idle(); perf_clr = 1; tick();
        idle(); ext_stall = 1;
        for (int k = 0; k < 65541; k++) tick();
        checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL sat_value got %h want ffff", stall_cycles); end
        perf_clr = 1; tick();
        checks++; if (stall_cycles !== 16'h0) begin errors++; $display("FAIL sat_clr got %h want 0000", stall_cycles); end
        perf_clr = 0; tick();
        checks++; if (stall_cycles !== 16'h1) begin errors++; $display("FAIL sat_restart got %h want 0001", stall_cycles); end
        $display("saturation: counter cleared and restarted at %0d", stall_cycles);
        idle(); tick();
    endtask

    task automatic test_reset_mid_stall();
        issue_w(7, 5); tick();
        consume(7); #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL rst_pre_hazard got %b want 1", hazard); end
        reset = 1; #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL rst_hazard got %b want 0", hazard); end
        checks++; if (stall !== 5'b0) begin errors++; $display("FAIL rst_stall got %b want 00000", stall); end
        checks++; if (stall_cycles !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h want 0000", stall_cycles); end
        tick();
        reset = 0; #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL rst_after got %b want 0", hazard); end
        $display("reset_mid_stall: hazard dropped");
        tick();
    endtask

    initial begin
        for (int r = 0; r < NR; r++) mc[r] = 0;
        mSc = 0;
        test_reset();
        test_raw();
        test_r0();
        test_stage_stall();
        test_waw();
        test_flush();
        test_random();
        test_saturation();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tiger_hazard_scoreboard.md
TIGER_HAZARD_SCOREBOARD -- requirements
Module: tiger_hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of pipeline stages; index 0 = decode, NUM_STAGES-1 = writeback.
REQ-002 SHALL have parameter NUM_REGS, default 32, architectural registers tracked; register 0 never tracked.
REQ-003 SHALL have parameter LAT_W, default 3, width of result-latency field; maximum latency is 2**LAT_W-1.
REQ-004 SHALL have parameter CNT_W, default 16, width of the performance counter.
REQ-005 SHALL have one clock and an asynchronous, active-high reset; the ports are clk and reset.
REQ-006 clk  in  1  clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 issue_valid  in  1  decode holds a valid instruction.
REQ-009 issue_rs, issue_rt  in  clog2(NUM_REGS) each  source register numbers.
REQ-010 issue_use_rs, issue_use_rt  in  1 each  source actually read.
REQ-011 issue_wr_en  in  1  instruction writes a register.
REQ-012 issue_wr_reg  in  clog2(NUM_REGS)  destination register.
REQ-013 issue_lat  in  LAT_W  advancing cycles until the result is forwardable (0 = immediately).
REQ-014 stage_stall_rq  in  NUM_STAGES  per-stage stall request (for example, multicycle execute or data-cache miss).
REQ-015 ext_stall  in  1  front-end (instruction-fetch) stall.
REQ-016 flush  in  1  exception flush.
REQ-017 perf_clr  in  1  synchronous clear of stall_cycles.
REQ-018 stall  out  NUM_STAGES  per-stage hold.
REQ-019 clear  out  NUM_STAGES  per-stage bubble insert.
REQ-020 hazard  out  1  RAW interlock active this cycle.
REQ-021 stall_cycles  out  CNT_W  saturating count of cycles with stall[0] high.

Function
REQ-022 Scoreboard: each register 1..NUM_REGS-1 SHALL hold a LAT_W-bit pending counter; pending means counter != 0.
REQ-023 hazard SHALL equal issue_valid && ((issue_use_rs && rs!=0 && pending[rs]) || (issue_use_rt && rt!=0 && pending[rt])); it is combinational from the current state.
REQ-024 need[0] SHALL be hazard || stage_stall_rq[0] || ext_stall; need[i] SHALL be stage_stall_rq[i] for i>=1.
REQ-025 stall[N-1] SHALL be need[N-1]; stall[i] SHALL be need[i] || stall[i+1]; there are no combinational loops.
REQ-026 clear[0] SHALL be flush && !stall[0]; clear[i] SHALL be need[i-1] && !stall[i] for i>=1.
REQ-027 Issue fires when issue_valid && issue_wr_en && issue_wr_reg!=0 && !stall[0] && !flush.
REQ-028 On issue, the counter SHALL load max(issue_lat, current-1 if it is decrementing, else current); this keeps WAW ordering safe.
REQ-029 All nonzero counters SHALL decrement by 1 in each cycle that stall[1] is low, and hold when stall[1] is high.
REQ-030 When issue and decrement hit the same register in the same cycle, REQ-028 governs.
REQ-031 Issue with issue_lat=0 SHALL leave the register not pending.
REQ-032 flush SHALL zero every counter on the next edge and suppress issue that cycle.
REQ-033 stall_cycles SHALL increment when stall[0] is high and saturate at all-ones; perf_clr SHALL zero it and takes priority over increment.
REQ-034 Latency: the scoreboard updates at the clock edge; stall, clear and hazard are same-cycle combinational.

Reset
REQ-035 Asserting reset SHALL immediately zero all counters and stall_cycles, independent of clk.
REQ-036 During reset, outputs SHALL follow REQ-023..026 with every register not pending.
REQ-037 Reset mid-stall SHALL drop a hazard-induced stall in the same cycle.

Structure
REQ-038 Package tiger_hazard_pkg SHALL hold default parameter values, the stage-index constants (STG_DE, STG_EX, STG_MA, STG_WB) and the latency type.
REQ-039 Sub-module tiger_sb_entry SHALL implement one pending counter (load, decrement, flush); it is instantiated NUM_REGS-1 times.

Verification
REQ-040 Issue wr_reg=5, lat=2, then a consumer with rs=5 → hazard=1 for 2 cycles, clear[1]=1 each cycle, then hazard=0.
REQ-041 Consumer of r0 after an r0 write with lat=3 → hazard stays 0.
REQ-042 stage_stall_rq[3]=1 for 4 cycles with r7 pending at 2 → stall[3:0]=4'hF, counter holds at 2, and the hazard persists 2 cycles after release.
REQ-043 r9 pending 1 with a new issue to r9 at lat=4 in the same cycle → counter=4; consumer stalls 4 cycles.
REQ-044 flush with r3,r4 pending → both clear next cycle, clear[0]=1, and a concurrent issue is ignored.
REQ-045 Hold stall[0] for 2**CNT_W+5 cycles → stall_cycles saturates at 16'hFFFF; perf_clr together with stall → 0.
